// File: rtl/fsd_pkg.sv
// Shared types and arithmetic helpers for the streaming
// Floyd-Steinberg ditherer.
package fsd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } fsd_state_t;

  function automatic int fsd_clamp(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int fsd_sat(int v, int w);
    return fsd_clamp(v, -(1 << (w - 1)), (1 << (w - 1)) - 1);
  endfunction

endpackage

// File: rtl/fs_dither_stream_if.sv
// Valid/ready stream bundle used on both sides of the ditherer.
// The master drives valid/data/last, the slave drives ready.
interface fs_dither_stream_if #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic         last;
  logic [W-1:0] data;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/fsd_line_buffer.sv
// One-row error line buffer: async read port, sync write port.
// Contents are not reset.
module fsd_line_buffer #(
  parameter int DEPTH = 64,
  parameter int W     = 13,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic signed [W-1:0] i_wdata,
  input  logic [AW-1:0]       i_raddr,
  output logic signed [W-1:0] o_rdata
);

  logic signed [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fs_dither_stream.sv
// Streaming Floyd-Steinberg ditherer, one pixel per clock.
// Define FSD_SERPENTINE_EN for right-to-left odd rows.
module fs_dither_stream
  import fsd_pkg::*;
#(
  parameter int IMAGEX   = 64,
  parameter int IMAGEY   = 64,
  parameter int PIX_W    = 8,
  parameter int OUT_BITS = 1,
  parameter int ERR_W    = PIX_W + 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  fs_dither_stream_if.slave  s,
  fs_dither_stream_if.master m,
  output logic         busy,
  output logic         frame_done
);

  localparam int XW   = $clog2(IMAGEX);
  localparam int YW   = (IMAGEY > 1) ? $clog2(IMAGEY) : 1;
  localparam int EW   = PIX_W + 1;
  localparam int AW   = PIX_W + 7;
  localparam int VMAX = (1 << PIX_W) - 1;
  localparam logic [XW-1:0] XMAX = XW'(IMAGEX - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMAGEY - 1);

  fsd_state_t              r_state;
  logic [XW-1:0]           r_x;
  logic [YW-1:0]           r_y;
  logic signed [ERR_W-1:0] r_p0;
  logic signed [ERR_W-1:0] r_p1;
  logic signed [EW-1:0]    r_ep;
  logic                    r_tail_v;
  logic [XW-1:0]           r_tail_a;
  logic signed [ERR_W-1:0] r_tail_d;
  logic                    r_mvalid;
  logic                    r_mlast;
  logic [OUT_BITS-1:0]     r_mdata;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_sready;
  logic                    w_acc_in;
  logic                    w_first;
  logic                    w_rlast;
  logic                    w_flast;
  logic [XW-1:0]           w_nb;
  logic [XW-1:0]           w_xnext;
  logic signed [ERR_W-1:0] w_rd;
  logic signed [ERR_W-1:0] w_eb;
  logic signed [AW-1:0]    w_acc;
  int                      w_rnd;
  logic [PIX_W-1:0]        w_v;
  logic [OUT_BITS-1:0]     w_q;
  logic [PIX_W-1:0]        w_recon;
  logic signed [EW-1:0]    w_e;
  logic signed [ERR_W-1:0] w_nbv;
  logic signed [ERR_W-1:0] w_p1n;
  logic                    w_we;
  logic [XW-1:0]           w_waddr;
  logic signed [ERR_W-1:0] w_wdata;
  logic                    w_unused;

  assign w_unused = s.last;

  assign w_sready = (r_state == RUN) &&
                    (!r_mvalid || m.ready);
  assign w_acc_in = w_sready && s.valid;

`ifdef FSD_SERPENTINE_EN
  logic w_odd;
  assign w_odd   = r_y[0];
  assign w_first = w_odd ? (r_x == XMAX) : (r_x == '0);
  assign w_rlast = w_odd ? (r_x == '0) : (r_x == XMAX);
  assign w_nb    = w_odd ? r_x + XW'(1) : r_x - XW'(1);
  assign w_xnext = w_rlast ? r_x :
                   (w_odd ? r_x - XW'(1) : r_x + XW'(1));
`else
  assign w_first = (r_x == '0);
  assign w_rlast = (r_x == XMAX);
  assign w_nb    = r_x - XW'(1);
  assign w_xnext = w_rlast ? '0 : r_x + XW'(1);
`endif

  assign w_flast = w_rlast && (r_y == YMAX);

  // The row-end cell is written a cycle late; bypass it if read first.
  assign w_eb = (r_y == '0) ? '0 :
                ((r_tail_v && r_tail_a == r_x) ? r_tail_d : w_rd);

  assign w_acc = AW'(int'(s.data) * 16 + int'(w_eb) +
                     7 * int'(r_ep));
  assign w_rnd = (int'(w_acc) + 8) >>> 4;
  assign w_v   = PIX_W'(fsd_clamp(w_rnd, 0, VMAX));
  assign w_q   = w_v[PIX_W-1 -: OUT_BITS];

  for (genvar i = 0; i < PIX_W; i++) begin : g_rec
    assign w_recon[i] =
      w_q[OUT_BITS - 1 - ((PIX_W - 1 - i) % OUT_BITS)];
  end

  assign w_e   = EW'(int'(w_v) - int'(w_recon));
  assign w_nbv = ERR_W'(fsd_sat(int'(r_p1) + 3 * int'(w_e), ERR_W));
  assign w_p1n = ERR_W'(fsd_sat(int'(r_p0) + 5 * int'(w_e), ERR_W));

  assign w_we    = r_tail_v || (w_acc_in && !w_first);
  assign w_waddr = r_tail_v ? r_tail_a : w_nb;
  assign w_wdata = r_tail_v ? r_tail_d : w_nbv;

  fsd_line_buffer #(
    .DEPTH (IMAGEX),
    .W     (ERR_W),
    .AW    (XW)
  ) u_lbuf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (r_x),
    .o_rdata (w_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_p0     <= '0;
      r_p1     <= '0;
      r_ep     <= '0;
      r_tail_v <= 1'b0;
      r_tail_a <= '0;
      r_tail_d <= '0;
      r_mvalid <= 1'b0;
      r_mlast  <= 1'b0;
      r_mdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_tail_v) r_tail_v <= 1'b0;
      if (r_mvalid && m.ready) begin
        r_mvalid <= 1'b0;
        r_mlast  <= 1'b0;
      end
      if (w_acc_in) begin
        r_mvalid <= 1'b1;
        r_mdata  <= w_q;
        r_mlast  <= w_flast;
        r_x      <= w_xnext;
        r_ep     <= w_rlast ? '0 : w_e;
        r_p1     <= w_rlast ? '0 : w_p1n;
        r_p0     <= w_rlast ? '0 : ERR_W'(w_e);
        if (w_rlast) begin
          r_y      <= r_y + YW'(1);
          r_tail_v <= 1'b1;
          r_tail_a <= r_x;
          r_tail_d <= w_p1n;
        end
      end
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_x     <= '0;
            r_y     <= '0;
            r_p0    <= '0;
            r_p1    <= '0;
            r_ep    <= '0;
          end
        end
        RUN: begin
          if (w_acc_in && w_flast) r_state <= DRAIN;
        end
        DRAIN: begin
          if (r_mvalid && m.ready && r_mlast) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s.ready    = w_sready;
  assign m.valid    = r_mvalid;
  assign m.data     = r_mdata;
  assign m.last     = r_mlast;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule
